axi4_lite_ram_slave: RTL and testbench

//  AXI4-Lite responder (slave end of interfaceAXI_4) fronting the instruction RAM.

---
 rtl/axi4_lite_ram_slave.sv | 247 ++++++++++++++++++++++++
 tb/tb_axi4_lite_ram_slave.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_ram_slave.sv
// AXI4-Lite responder that turns AW/W/AR requests into single-port SRAM accesses.
// One transaction is in flight at a time. Out-of-range word indices answer SLVERR and do not touch the RAM.
module axi4_lite_ram_slave #(
    parameter int ADDR_SIZE = 24,
    parameter int DATA_SIZE = 32,
    parameter int MEM_WORDS = 1024,
    localparam int STRB_SIZE = DATA_SIZE / 8,
    localparam int MEM_AW = $clog2(MEM_WORDS)
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    input  logic                 awvalid,
    output logic                 awready,
    input  logic [ADDR_SIZE-1:0] awaddr,
    input  logic [2:0]           awprot,
    input  logic                 wvalid,
    output logic                 wready,
    input  logic [DATA_SIZE-1:0] wdata,
    input  logic [STRB_SIZE-1:0] wstrb,
    output logic                 bvalid,
    input  logic                 bready,
    output logic [1:0]           bresp,
    input  logic                 arvalid,
    output logic                 arready,
    input  logic [ADDR_SIZE-1:0] araddr,
    input  logic [2:0]           arprot,
    output logic                 rvalid,
    input  logic                 rready,
    output logic [DATA_SIZE-1:0] rdata,
    output logic [1:0]           rresp,
    output logic                 mem_en,
    output logic [STRB_SIZE-1:0] mem_we,
    output logic [MEM_AW-1:0]    mem_addr,
    output logic [DATA_SIZE-1:0] mem_wdata,
    input  logic [DATA_SIZE-1:0] mem_rdata
);

    localparam int BYTE_BITS = (STRB_SIZE > 1) ? $clog2(STRB_SIZE) : 1;
    localparam int IDX_W     = ADDR_SIZE - BYTE_BITS;
    localparam logic [IDX_W-1:0] WORDS_LIM = IDX_W'(MEM_WORDS);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic GRANT_READ  = 1'b0;
    localparam logic GRANT_WRITE = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        WR_MEM,
        WR_RESP,
        RD_MEM,
        RD_CAP,
        RD_RESP
    } state_t;

    state_t               state_reg, state_next;
    logic                 aw_full_reg, aw_full_next;
    logic [IDX_W-1:0]     aw_idx_reg, aw_idx_next;
    logic                 w_full_reg, w_full_next;
    logic [DATA_SIZE-1:0] w_data_reg, w_data_next;
    logic [STRB_SIZE-1:0] w_strb_reg, w_strb_next;
    logic [IDX_W-1:0]     ar_idx_reg, ar_idx_next;
    logic                 last_grant_reg, last_grant_next;
    logic                 awready_reg, awready_next;
    logic                 wready_reg, wready_next;
    logic                 arready_reg, arready_next;
    logic                 bvalid_reg, bvalid_next;
    logic [1:0]           bresp_reg, bresp_next;
    logic                 rvalid_reg, rvalid_next;
    logic [1:0]           rresp_reg, rresp_next;
    logic [DATA_SIZE-1:0] rdata_reg, rdata_next;
    logic                 mem_en_reg, mem_en_next;
    logic [STRB_SIZE-1:0] mem_we_reg, mem_we_next;
    logic [MEM_AW-1:0]    mem_addr_reg, mem_addr_next;
    logic [DATA_SIZE-1:0] mem_wdata_reg, mem_wdata_next;

    logic [IDX_W-1:0] awaddr_idx;
    logic [IDX_W-1:0] araddr_idx;
    logic             aw_in_range;
    logic             ar_in_range;
    logic             araddr_in_range;
    logic             aw_hs;
    logic             w_hs;
    logic             ar_hs;
    logic             wr_pair;
    logic             unused_bits;

    assign awaddr_idx      = awaddr[ADDR_SIZE-1:BYTE_BITS];
    assign araddr_idx      = araddr[ADDR_SIZE-1:BYTE_BITS];
    assign aw_in_range     = (aw_idx_reg < WORDS_LIM);
    assign ar_in_range     = (ar_idx_reg < WORDS_LIM);
    assign araddr_in_range = (araddr_idx < WORDS_LIM);
    assign aw_hs           = awvalid && awready_reg;
    assign w_hs            = wvalid && wready_reg;
    assign ar_hs           = arvalid && arready_reg;
    assign wr_pair         = aw_full_reg && w_full_reg;

    // Protection bits and sub-word address bits carry no meaning for this RAM.
    assign unused_bits = ^{awprot, arprot, awaddr[BYTE_BITS-1:0], araddr[BYTE_BITS-1:0]};

    always_comb begin
        state_next      = state_reg;
        aw_full_next    = aw_full_reg;
        aw_idx_next     = aw_idx_reg;
        w_full_next     = w_full_reg;
        w_data_next     = w_data_reg;
        w_strb_next     = w_strb_reg;
        ar_idx_next     = ar_idx_reg;
        last_grant_next = last_grant_reg;
        bvalid_next     = bvalid_reg;
        bresp_next      = bresp_reg;
        rvalid_next     = rvalid_reg;
        rresp_next      = rresp_reg;
        rdata_next      = rdata_reg;
        mem_en_next     = 1'b0;
        mem_we_next     = '0;
        mem_addr_next   = '0;
        mem_wdata_next  = '0;

        // Holding registers fill independently of the FSM, so a new AW/W can queue behind a busy op.
        if (aw_hs) begin
            aw_full_next = 1'b1;
            aw_idx_next  = awaddr_idx;
        end
        if (w_hs) begin
            w_full_next = 1'b1;
            w_data_next = wdata;
            w_strb_next = wstrb;
        end

        case (state_reg)
            IDLE: begin
                // arready already encodes the alternation, so an accepted AR always wins here.
                if (ar_hs) begin
                    ar_idx_next   = araddr_idx;
                    state_next    = RD_MEM;
                    mem_en_next   = araddr_in_range;
                    mem_addr_next = araddr_in_range ? araddr_idx[MEM_AW-1:0] : '0;
                end else if (wr_pair) begin
                    state_next     = WR_MEM;
                    mem_en_next    = aw_in_range;
                    mem_we_next    = aw_in_range ? w_strb_reg : '0;
                    mem_addr_next  = aw_in_range ? aw_idx_reg[MEM_AW-1:0] : '0;
                    mem_wdata_next = aw_in_range ? w_data_reg : '0;
                end
            end
            WR_MEM: begin
                aw_full_next = 1'b0;
                w_full_next  = 1'b0;
                bvalid_next  = 1'b1;
                bresp_next   = aw_in_range ? RESP_OKAY : RESP_SLVERR;
                state_next   = WR_RESP;
            end
            WR_RESP: begin
                if (bready) begin
                    bvalid_next     = 1'b0;
                    last_grant_next = GRANT_WRITE;
                    state_next      = IDLE;
                end
            end
            RD_MEM: begin
                state_next = RD_CAP;
            end
            RD_CAP: begin
                rdata_next  = ar_in_range ? mem_rdata : '0;
                rresp_next  = ar_in_range ? RESP_OKAY : RESP_SLVERR;
                rvalid_next = 1'b1;
                state_next  = RD_RESP;
            end
            RD_RESP: begin
                if (rready) begin
                    rvalid_next     = 1'b0;
                    last_grant_next = GRANT_READ;
                    state_next      = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        awready_next = !aw_full_next;
        wready_next  = !w_full_next;
        // A complete write pair blocks reads only when the previous grant went to a read.
        arready_next = (state_next == IDLE) &&
                       !(aw_full_next && w_full_next && (last_grant_next == GRANT_READ));
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_reg      <= IDLE;
            aw_full_reg    <= 1'b0;
            aw_idx_reg     <= '0;
            w_full_reg     <= 1'b0;
            w_data_reg     <= '0;
            w_strb_reg     <= '0;
            ar_idx_reg     <= '0;
            last_grant_reg <= GRANT_READ;
            awready_reg    <= 1'b0;
            wready_reg     <= 1'b0;
            arready_reg    <= 1'b0;
            bvalid_reg     <= 1'b0;
            bresp_reg      <= RESP_OKAY;
            rvalid_reg     <= 1'b0;
            rresp_reg      <= RESP_OKAY;
            rdata_reg      <= '0;
            mem_en_reg     <= 1'b0;
            mem_we_reg     <= '0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            aw_full_reg    <= aw_full_next;
            aw_idx_reg     <= aw_idx_next;
            w_full_reg     <= w_full_next;
            w_data_reg     <= w_data_next;
            w_strb_reg     <= w_strb_next;
            ar_idx_reg     <= ar_idx_next;
            last_grant_reg <= last_grant_next;
            awready_reg    <= awready_next;
            wready_reg     <= wready_next;
            arready_reg    <= arready_next;
            bvalid_reg     <= bvalid_next;
            bresp_reg      <= bresp_next;
            rvalid_reg     <= rvalid_next;
            rresp_reg      <= rresp_next;
            rdata_reg      <= rdata_next;
            mem_en_reg     <= mem_en_next;
            mem_we_reg     <= mem_we_next;
            mem_addr_reg   <= mem_addr_next;
            mem_wdata_reg  <= mem_wdata_next;
        end
    end

    assign awready   = awready_reg;
    assign wready    = wready_reg;
    assign arready   = arready_reg;
    assign bvalid    = bvalid_reg;
    assign bresp     = bresp_reg;
    assign rvalid    = rvalid_reg;
    assign rresp     = rresp_reg;
    assign rdata     = rdata_reg;
    assign mem_en    = mem_en_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_axi4_lite_ram_slave.sv
// Directed and randomized bench for axi4_lite_ram_slave with an attached behavioural RAM
// and a word-array reference model of expected memory contents.
module tb_axi4_lite_ram_slave;

    localparam int WORDS = 1024;

    logic        ACLK;
    logic        ARESET;
    logic        awvalid, awready;
    logic [23:0] awaddr;
    logic [2:0]  awprot;
    logic        wvalid, wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid, bready;
    logic [1:0]  bresp;
    logic        arvalid, arready;
    logic [23:0] araddr;
    logic [2:0]  arprot;
    logic        rvalid, rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int errors = 0;
    int checks = 0;
    int mem_en_cnt = 0;

    logic [31:0] ram     [WORDS];
    logic [31:0] ref_mem [WORDS];

    axi4_lite_ram_slave #(.ADDR_SIZE(24), .DATA_SIZE(32), .MEM_WORDS(WORDS)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // Synchronous single-port RAM: read data appears one cycle after an enabled read.
    always @(posedge ACLK) begin
        if (mem_en) begin
            mem_en_cnt <= mem_en_cnt + 1;
            if (mem_we == 4'b0000)
                mem_rdata <= ram[mem_addr];
            else
                for (int b = 0; b < 4; b++)
                    if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_write(input logic [23:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, output logic [1:0] resp);
        int idx;
        idx = int'(addr) / 4;
        if (idx < WORDS) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) ref_mem[idx][8*b +: 8] = data[8*b +: 8];
            resp = 2'b00;
        end else begin
            resp = 2'b10;
        end
    endtask

    task automatic model_read(input logic [23:0] addr, output logic [31:0] data,
                              output logic [1:0] resp);
        int idx;
        idx = int'(addr) / 4;
        if (idx < WORDS) begin
            data = ref_mem[idx];
            resp = 2'b00;
        end else begin
            data = 32'h0;
            resp = 2'b10;
        end
    endtask

    // W is presented 'lead' cycles before AW; returns on the negedge after the last handshake.
    task automatic send_write(input logic [23:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, input int lead);
        bit aw_done, w_done, aw_fire, w_fire;
        int cyc;
        aw_done = 0; w_done = 0; cyc = 0;
        wdata = data; wstrb = strb; wvalid = 1'b1;
        awaddr = addr; awvalid = (lead == 0);
        while (!(aw_done && w_done) && cyc < 40) begin
            aw_fire = awvalid && awready;
            w_fire  = wvalid && wready;
            @(negedge ACLK);
            cyc++;
            if (aw_fire) begin awvalid = 1'b0; aw_done = 1; end
            if (w_fire)  begin wvalid = 1'b0; w_done = 1; end
            if (!aw_done && cyc >= lead) awvalid = 1'b1;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        check("wr_accept", {62'h0, aw_done, w_done}, 64'h3);
    endtask

    task automatic wait_b(input logic [1:0] exp_resp, input string tag);
        int n;
        n = 0;
        while (!bvalid && n < 30) begin @(negedge ACLK); n++; end
        check({tag, "_bvalid"}, bvalid, 1);
        check({tag, "_bresp"}, bresp, exp_resp);
        bready = 1'b1;
        @(negedge ACLK);
        bready = 1'b0;
        check({tag, "_bdrop"}, bvalid, 0);
    endtask

    task automatic send_ar(input logic [23:0] addr);
        int n;
        n = 0;
        araddr = addr; arvalid = 1'b1;
        while (!arready && n < 30) begin @(negedge ACLK); n++; end
        check("ar_accept", arready, 1);
        @(negedge ACLK);
        arvalid = 1'b0;
    endtask

    task automatic wait_r(input logic [31:0] exp_data, input logic [1:0] exp_resp, input string tag);
        int n;
        n = 0;
        while (!rvalid && n < 30) begin @(negedge ACLK); n++; end
        check({tag, "_rvalid"}, rvalid, 1);
        check({tag, "_rdata"}, rdata, exp_data);
        check({tag, "_rresp"}, rresp, exp_resp);
        rready = 1'b1;
        @(negedge ACLK);
        rready = 1'b0;
        check({tag, "_rdrop"}, rvalid, 0);
    endtask

    task automatic do_write(input logic [23:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int lead, input string tag);
        logic [1:0] resp;
        model_write(addr, data, strb, resp);
        send_write(addr, data, strb, lead);
        wait_b(resp, tag);
        $display("WRITE %s addr=%06h data=%08h strb=%h lead=%0d exp_bresp=%0d", tag, addr, data, strb, lead, resp);
    endtask

    task automatic do_read(input logic [23:0] addr, input string tag);
        logic [31:0] d;
        logic [1:0]  resp;
        model_read(addr, d, resp);
        send_ar(addr);
        wait_r(d, resp, tag);
        $display("READ  %s addr=%06h exp_data=%08h exp_rresp=%0d got=%08h", tag, addr, d, resp, rdata);
    endtask

    initial begin
        logic [31:0] exp_d, hold_d;
        logic [1:0]  exp_r, w1_resp, w2_resp;
        logic [23:0] a;
        int cnt0, n;

        for (int i = 0; i < WORDS; i++) begin ram[i] = '0; ref_mem[i] = '0; end
        ARESET = 1'b1;
        awvalid = 0; awaddr = 0; awprot = 0; wvalid = 0; wdata = 0; wstrb = 0;
        bready = 0; arvalid = 0; araddr = 0; arprot = 0; rready = 0;

        // Reset state
        @(negedge ACLK); @(negedge ACLK);
        check("rst_ctl", {awready, wready, arready, bvalid, rvalid, bresp, rresp, mem_en, mem_we}, 0);
        check("rst_data", {rdata, mem_wdata}, 0);
        check("rst_addr", mem_addr, 0);
        ARESET = 1'b0;
        @(negedge ACLK);
        check("rel_readies", {awready, wready, arready}, 3'b111);

        // Same-cycle AW/W write with exact response timing
        model_write(24'h10, 32'hDEADBEEF, 4'hF, exp_r);
        send_write(24'h10, 32'hDEADBEEF, 4'hF, 0);
        check("wr_lat0_bvalid", bvalid, 0);
        @(negedge ACLK);
        check("wr_lat1_bvalid", bvalid, 0);
        check("wr_mem_ctl", {mem_en, mem_we, mem_addr}, {1'b1, 4'hF, 10'd4});
        check("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
        @(negedge ACLK);
        check("wr_lat2_bvalid", bvalid, 1);
        wait_b(exp_r, "t2");
        $display("WRITE t2 addr=000010 data=deadbeef strb=f");
        do_read(24'h10, "t2_rd");

        // W two cycles ahead of AW, partial strobes
        do_write(24'h20, 32'hFFFFFFFF, 4'hF, 0, "t3_fill");
        do_write(24'h20, 32'h0000A5A5, 4'b0011, 2, "t3_part");
        model_read(24'h20, exp_d, exp_r);
        check("t3_model", exp_d, 32'hFFFFA5A5);
        do_read(24'h20, "t3_rd");

        // Out-of-range read and write
        cnt0 = mem_en_cnt;
        do_read(24'h1000, "t4_rd");
        do_write(24'h1000, 32'h12345678, 4'hF, 0, "t4_wr");
        check("t4_no_mem", mem_en_cnt, cnt0);

        // Contention: write wins after a read, then read wins after a write
        model_read(24'h10, exp_d, exp_r);
        send_ar(24'h10);
        n = 0;
        while (!rvalid && n < 30) begin @(negedge ACLK); n++; end
        hold_d = rdata;
        model_write(24'h40, 32'hCAFE0001, 4'hF, w1_resp);
        send_write(24'h40, 32'hCAFE0001, 4'hF, 0);
        araddr = 24'h20; arvalid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge ACLK);
            check("t5_r_hold", {rvalid, rdata, rresp}, {1'b1, hold_d, 2'b00});
        end
        check("t5_r_data", hold_d, exp_d);
        rready = 1'b1; @(negedge ACLK); rready = 1'b0;
        n = 0;
        while (!bvalid && n < 30) begin
            check("t5_ar_blocked", arready, 0);
            @(negedge ACLK); n++;
        end
        check("t5_w_first", {bvalid, rvalid}, 2'b10);
        hold_d = {30'h0, bresp};
        model_write(24'h44, 32'hCAFE0002, 4'hF, w2_resp);
        send_write(24'h44, 32'hCAFE0002, 4'hF, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge ACLK);
            check("t5_b_hold", {bvalid, bresp}, {1'b1, w1_resp});
        end
        bready = 1'b1; @(negedge ACLK); bready = 1'b0;
        n = 0;
        while (!arready && n < 30) begin @(negedge ACLK); n++; end
        check("t5_ar_granted", arready, 1);
        @(negedge ACLK); arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 30) begin @(negedge ACLK); n++; end
        model_read(24'h20, exp_d, exp_r);
        check("t5_r_first", {rvalid, bvalid}, 2'b10);
        wait_r(exp_d, exp_r, "t5_rd");
        wait_b(w2_resp, "t5_wr2");
        $display("CONTEND t5 write-then-read, read-then-write done");
        do_read(24'h44, "t5_rb");

        // Reset pulse while the read sits in the capture state
        send_ar(24'h10);
        @(negedge ACLK);
        ARESET = 1'b1;
        #1;
        check("t6_rst_out", {awready, wready, arready, bvalid, rvalid, mem_en}, 0);
        @(negedge ACLK);
        ARESET = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge ACLK);
            check("t6_no_rvalid", rvalid, 0);
        end
        check("t6_idle_readies", {awready, wready, arready}, 3'b111);
        $display("RESET t6 pulse during read capture");
        do_read(24'h10, "t6_rd");

        // Randomized mix against the reference model
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 5) == 0)
                a = 24'(WORDS * 4 + $urandom_range(0, 255));
            else
                a = 24'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1)
                do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2), "rnd_wr");
            else
                do_read(a, "rnd_rd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
